// File: rtl/vga_timing_gen_pkg.sv
// vga_timing_pkg
//   Shared constants for the 640x480 @ 60 Hz VGA timing generator.
//   Holds the default sync/porch/visible widths, the derived totals and
//   visible-window bounds, and the 10-bit coordinate type used on every
//   counter and coordinate output.
package vga_timing_pkg;

  // Default timing (pixels for horizontal, lines for vertical).
  localparam int DEF_CLK_DIV   = 2;
  localparam int DEF_H_SYNC    = 96;
  localparam int DEF_H_BACK    = 48;
  localparam int DEF_H_VISIBLE = 640;
  localparam int DEF_H_FRONT   = 16;
  localparam int DEF_V_SYNC    = 2;
  localparam int DEF_V_BACK    = 33;
  localparam int DEF_V_VISIBLE = 480;
  localparam int DEF_V_FRONT   = 10;

  // Derived totals and visible window (start inclusive, end exclusive).
  localparam int H_TOTAL     = DEF_H_SYNC + DEF_H_BACK + DEF_H_VISIBLE + DEF_H_FRONT;
  localparam int V_TOTAL     = DEF_V_SYNC + DEF_V_BACK + DEF_V_VISIBLE + DEF_V_FRONT;
  localparam int H_VIS_START = DEF_H_SYNC + DEF_H_BACK;
  localparam int H_VIS_END   = H_VIS_START + DEF_H_VISIBLE;
  localparam int V_VIS_START = DEF_V_SYNC + DEF_V_BACK;
  localparam int V_VIS_END   = V_VIS_START + DEF_V_VISIBLE;

  typedef logic [9:0] coord_t;

endpackage

// File: rtl/vga_timing_gen_if.sv
// vga_timing_gen_if
//   Video timing bundle driven by vga_timing_gen.
//   master: timing generator (drives everything)
//   slave : pixel/colour stage (samples on pix_en cycles)
//   Signals: hsync, vsync (active low), bright, pix_en, frame_start,
//            hcount, vcount, x, y (10-bit coordinates).
interface vga_timing_gen_if;
  import vga_timing_pkg::*;

  logic   hsync;
  logic   vsync;
  logic   bright;
  logic   pix_en;
  logic   frame_start;
  coord_t hcount;
  coord_t vcount;
  coord_t x;
  coord_t y;

  modport master (
    output hsync, vsync, bright, pix_en, frame_start, hcount, vcount, x, y
  );

  modport slave (
    input hsync, vsync, bright, pix_en, frame_start, hcount, vcount, x, y
  );
endinterface

// File: rtl/vga_timing_gen_pixel_tick.sv
// vga_pixel_tick
//   Pixel-rate enable divider: one-clk strobe every CLK_DIV system clocks.
//   Ports: clk, reset (sync, active high), pix_en (strobe out).
//   CLK_DIV legal range 1..16, so a 4-bit divide counter is enough.
module vga_pixel_tick #(
  parameter int CLK_DIV = 2
) (
  input  logic clk,
  input  logic reset,
  output logic pix_en
);

  localparam logic [3:0] DIV_LAST = 4'(CLK_DIV - 1);

  logic [3:0] div_cnt_reg;

  always_ff @(posedge clk) begin
    if (reset) begin
      div_cnt_reg <= '0;
    end else if (div_cnt_reg == DIV_LAST) begin
      div_cnt_reg <= '0;
    end else begin
      div_cnt_reg <= div_cnt_reg + 1'b1;
    end
  end

  // Gated by reset so that CLK_DIV=1 (DIV_LAST=0) still reads 0 while
  // reset is held.
  assign pix_en = !reset && (div_cnt_reg == DIV_LAST);

endmodule

// File: rtl/vga_timing_gen.sv
// vga_timing_gen
//   640x480 @ 60 Hz VGA timing generator (defaults; all widths overridable).
//   Ports: clk, reset (sync, active high), bus (vga_timing_gen_if.master):
//     hsync/vsync  active-low syncs, registered, aligned with the counters
//     bright       visible-window flag, registered, aligned with the counters
//     hcount/vcount free-running position, advanced on pix_en
//     pix_en       pixel strobe, once every CLK_DIV clks
//     x/y          position inside the visible window (0 when not bright)
//     frame_start  high while the position is (0,0)
//   Line and frame order: sync, back porch, visible, front porch.
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int CLK_DIV   = DEF_CLK_DIV,
  parameter int H_SYNC    = DEF_H_SYNC,
  parameter int H_BACK    = DEF_H_BACK,
  parameter int H_VISIBLE = DEF_H_VISIBLE,
  parameter int H_FRONT   = DEF_H_FRONT,
  parameter int V_SYNC    = DEF_V_SYNC,
  parameter int V_BACK    = DEF_V_BACK,
  parameter int V_VISIBLE = DEF_V_VISIBLE,
  parameter int V_FRONT   = DEF_V_FRONT
) (
  input  logic             clk,
  input  logic             reset,
  vga_timing_gen_if.master bus
);

  localparam coord_t LINE_LAST  = coord_t'(H_SYNC + H_BACK + H_VISIBLE + H_FRONT - 1);
  localparam coord_t FRAME_LAST = coord_t'(V_SYNC + V_BACK + V_VISIBLE + V_FRONT - 1);
  localparam coord_t HSYNC_END  = coord_t'(H_SYNC);
  localparam coord_t VSYNC_END  = coord_t'(V_SYNC);
  localparam coord_t VIS_H0     = coord_t'(H_SYNC + H_BACK);
  localparam coord_t VIS_H1     = coord_t'(H_SYNC + H_BACK + H_VISIBLE);
  localparam coord_t VIS_V0     = coord_t'(V_SYNC + V_BACK);
  localparam coord_t VIS_V1     = coord_t'(V_SYNC + V_BACK + V_VISIBLE);

  logic   pix_en;
  coord_t hcount_reg, hcount_next;
  coord_t vcount_reg, vcount_next;
  logic   hsync_reg, hsync_next;
  logic   vsync_reg, vsync_next;
  logic   bright_reg, bright_next;

  vga_pixel_tick #(
    .CLK_DIV(CLK_DIV)
  ) u_pixel_tick (
    .clk   (clk),
    .reset (reset),
    .pix_en(pix_en)
  );

  // Position advance; the last pixel of the last line wraps both to 0.
  always_comb begin
    hcount_next = hcount_reg;
    vcount_next = vcount_reg;
    if (pix_en) begin
      if (hcount_reg == LINE_LAST) begin
        hcount_next = '0;
        vcount_next = (vcount_reg == FRAME_LAST) ? '0 : vcount_reg + 1'b1;
      end else begin
        hcount_next = hcount_reg + 1'b1;
      end
    end
  end

  // Flags are decoded from the next position so that, once registered,
  // they line up with the counters without any lag.
  always_comb begin
    hsync_next  = (hcount_next >= HSYNC_END);
    vsync_next  = (vcount_next >= VSYNC_END);
    bright_next = (hcount_next >= VIS_H0) && (hcount_next < VIS_H1) &&
                  (vcount_next >= VIS_V0) && (vcount_next < VIS_V1);
  end

  // Reset parks the position on the last pixel of the frame so the first
  // pixel tick lands on (0,0) and the flags already match that position.
  always_ff @(posedge clk) begin
    if (reset) begin
      hcount_reg <= LINE_LAST;
      vcount_reg <= FRAME_LAST;
      hsync_reg  <= 1'b1;
      vsync_reg  <= 1'b1;
      bright_reg <= 1'b0;
    end else begin
      hcount_reg <= hcount_next;
      vcount_reg <= vcount_next;
      hsync_reg  <= hsync_next;
      vsync_reg  <= vsync_next;
      bright_reg <= bright_next;
    end
  end

  assign bus.hcount      = hcount_reg;
  assign bus.vcount      = vcount_reg;
  assign bus.hsync       = hsync_reg;
  assign bus.vsync       = vsync_reg;
  assign bus.bright      = bright_reg;
  assign bus.pix_en      = pix_en;
  assign bus.x           = bright_reg ? (hcount_reg - VIS_H0) : '0;
  assign bus.y           = bright_reg ? (vcount_reg - VIS_V0) : '0;
  assign bus.frame_start = (hcount_reg == '0) && (vcount_reg == '0);

endmodule

// File: doc/vga_timing_gen.md
Name: vga_timing_gen

Overview:
Generates 640x480 @ 60 Hz VGA timing from the board system clock. It produces the hsync/vsync pins, the bright (active-video) flag and the free-running hcount/vcount coordinates. The pixel colour stage directly downstream consumes these and blanks its colour outputs outside hcount 144..783.
The block also provides a pixel-rate clock enable, frame-relative pixel coordinates and a frame-start marker.

Parameters:
CLK_DIV, 2, system clocks per pixel (50 MHz -> 25 MHz); legal 1..16
H_SYNC, 96, horizontal sync width, pixels
H_BACK, 48, horizontal back porch
H_VISIBLE, 640, visible pixels per line
H_FRONT, 16, horizontal front porch
V_SYNC, 2, vertical sync width, lines
V_BACK, 33, vertical back porch
V_VISIBLE, 480, visible lines
V_FRONT, 10, vertical front porch

Ports:
clk  input  1  system clock, single clock domain
reset  input  1  synchronous, active-high reset
hsync  output  1  horizontal sync, active low
vsync  output  1  vertical sync, active low
bright  output  1  high only inside the visible window
hcount  output  10  horizontal position 0..H_TOTAL-1 (H_TOTAL=800)
vcount  output  10  vertical position 0..V_TOTAL-1 (V_TOTAL=525)
pix_en  output  1  one-clk pixel strobe, once every CLK_DIV clks
x  output  10  hcount-(H_SYNC+H_BACK) when bright, else 0
y  output  10  vcount-(V_SYNC+V_BACK) when bright, else 0
frame_start  output  1  high while hcount==0 and vcount==0

Behaviour:
- Interface: one clock (clk); reset is synchronous and active-high.
- Line order and frame order are both sync, back porch, visible, front porch.
- Horizontal: sync is hcount 0..95, visible is 144..783, front porch is 784..799.
- Vertical: sync is vcount 0..1, visible is 35..514, front porch is 515..524.
- Divider: div_cnt resets to 0, increments every clk and wraps at CLK_DIV-1. pix_en = (div_cnt==CLK_DIV-1), decoded from the register. With CLK_DIV=1, pix_en is constantly 1 outside reset.
- Counters advance only on a clk edge where pix_en=1.
  - hcount increments, wrapping from 799 to 0.
  - On the wrap, vcount increments, wrapping from 524 to 0.
  - When hcount==799 and vcount==524 on the same tick, both counters go to 0 together.
- hsync, vsync and bright are registered and updated on the same edge as the counters, computed from the next count values. They are therefore always consistent with the current hcount/vcount (zero relative latency).
- x, y and frame_start are combinational decodes of the registered counters.
- Reset values (held for every cycle reset is high): hcount=799, vcount=524, div_cnt=0, hsync=1, vsync=1, bright=0, pix_en=0, x=0, y=0, frame_start=0.
  - These match the decode of position (799,524), so no inconsistent state ever appears.
  - First pix_en: CLK_DIV clks after reset deasserts, that pix_en tick moves the counters to (0,0).
- Reset mid-frame: all state returns to the reset values on the next clk edge, with no partial-line output.
- Width rules:
  - Counters are 10 bits and never exceed 799 or 524.
  - x and y are 10-bit unsigned subtractions, valid only when bright=1.
- Downstream contract: consumers sample colour/coordinates on pix_en cycles. Each position is held for exactly CLK_DIV clks.

Decomposition:
- Package vga_timing_pkg holds:
  - the porch/sync/visible constants;
  - derived H_TOTAL, V_TOTAL, H_VIS_START=144, H_VIS_END=784, V_VIS_START=35, V_VIS_END=515;
  - a 10-bit coord_t typedef.
- One sub-module, vga_pixel_tick: parameterised CLK_DIV enable divider producing pix_en, with synchronous reset.

Test Plan:
- Reset: hold reset 5 clks -> hcount=799, vcount=524, hsync=vsync=1, bright=0, pix_en=0. Release -> pix_en first high at clk 2 (CLK_DIV=2), then hcount=0, vcount=0, frame_start=1, hsync=0.
- Pixel strobe: run 100 clks with CLK_DIV=2 -> pix_en alternates 0,1 with exactly 50 pulses; each hcount value is held 2 clks.
- Line timing on vcount=35 -> hsync=0 exactly for hcount 0..95; bright=1 exactly for hcount 144..783; x=0 at hcount 144 and x=639 at 783; y=0.
- Wrap: at (799,34) next tick -> (0,35). At (799,524) next tick -> (0,0), frame_start=1; vsync=0 for vcount 0..1 only.
- Frame period: count clks between frame_start rising edges -> 840000 (800 x 525 x 2). Count bright=1 pixel ticks per frame -> 307200.
- Reset mid-frame: assert reset at (400,200) for 1 clk -> next cycle shows reset values. Timing restarts and frame_start follows after 2 clks.
